// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller in front of a registered-read dual-port RAM.
// A 2-entry output buffer hides the RAM read latency so the read side never bubbles.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [ADDR_WIDTH+1:0]   count,
    output logic                    ram_we,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [ADDR_WIDTH-1:0]   ram_waddr,
    output logic [ADDR_WIDTH-1:0]   ram_raddr,
    input  logic [DATA_WIDTH-1:0]   ram_q
);

    localparam logic [ADDR_WIDTH:0]   RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   PTR_ONE   = 1;
    localparam logic [ADDR_WIDTH+1:0] CNT_ONE   = 1;

    logic                  rst_n_q;
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  ram_full;
    logic                  ram_empty;
    logic                  accept;
    logic                  pop;
    logic                  pending;
    logic                  rd_issue;
    logic [2:0]            rd_load;
    logic [1:0]            buf_occ;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;

    assign ram_cnt   = wptr - rptr;
    assign ram_full  = (ram_cnt == RAM_DEPTH);
    assign ram_empty = (ram_cnt == '0);

    assign s_ready   = rst_n_q & ~ram_full;
    assign accept    = s_valid & s_ready;
    assign m_valid   = (buf_occ != 2'd0);
    assign m_data    = buf0;
    assign pop       = m_valid & m_ready;

    // Only issue a read if the buffer is guaranteed room when its data lands next cycle.
    assign rd_load   = 3'(buf_occ) + 3'(pending) - 3'(pop);
    assign rd_issue  = ~ram_empty & (rd_load < 3'd2);

    assign ram_we    = accept;
    assign ram_wdata = s_data;
    assign ram_waddr = wptr[ADDR_WIDTH-1:0];
    assign ram_raddr = rptr[ADDR_WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            pending <= 1'b0;
            buf_occ <= 2'd0;
            count   <= '0;
        end else begin
            rst_n_q <= 1'b1;
            pending <= rd_issue;
            if (accept)
                wptr <= wptr + PTR_ONE;
            if (rd_issue)
                rptr <= rptr + PTR_ONE;
            if (pending && !pop)
                buf_occ <= buf_occ + 2'd1;
            else if (pop && !pending)
                buf_occ <= buf_occ - 2'd1;
            if (accept && !pop)
                count <= count + CNT_ONE;
            else if (pop && !accept)
                count <= count - CNT_ONE;
        end
    end

    // NOTE: buffer data is left unreset; buf_occ alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        unique case ({pending, pop})
            2'b10: begin
                if (buf_occ == 2'd0)
                    buf0 <= ram_q;
                else
                    buf1 <= ram_q;
            end
            2'b01: buf0 <= buf1;
            2'b11: begin
                if (buf_occ == 2'd2) begin
                    buf0 <= buf1;
                    buf1 <= ram_q;
                end else begin
                    buf0 <= ram_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed and randomised bench for fifo_ctrl with a behavioural registered-read RAM.
module tb_fifo_ctrl;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .count     (count),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple dual-port RAM: registered read, one cycle latency, no reset.
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
        ram_q <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] sb [$];
        logic [DW-1:0] prev_data;
        logic          prev_stall;
        logic          seen;
        logic          got;
        int            e, wi, ri, nacc;

        // Reset held for 3 cycles with s_valid asserted
        rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b0;
        repeat (3) begin
            cyc; #1;
            check("rst_s_ready", s_ready, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_count", count, 0);
            check("rst_ram_we", ram_we, 0);
        end
        rst_n = 1'b1; s_valid = 1'b0;
        #1 check("rel_s_ready_low", s_ready, 0);
        cyc; #1 check("rel_s_ready_high", s_ready, 1);

        // Single word latency
        cyc; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        #1 check("single_we", ram_we, 1);
        check("single_waddr", ram_waddr, 0);
        cyc; s_valid = 1'b0;
        #1 check("single_raddr", ram_raddr, 0);
        check("single_c1_count", count, 1);
        check("single_c1_valid", m_valid, 0);
        cyc; #1 check("single_c2_valid", m_valid, 0);
        cyc; #1 check("single_c3_valid", m_valid, 1);
        check("single_c3_data", m_data, 8'hA5);
        cyc; #1 check("single_c4_count", count, 0);
        check("single_c4_valid", m_valid, 0);

        // Fill to 66 words with no reads
        m_ready = 1'b0;
        for (int i = 0; i < 66; i++) begin
            cyc; s_valid = 1'b1; s_data = DW'(i);
            #1 check("fill_ready", s_ready, 1);
        end
        cyc; s_valid = 1'b0;
        repeat (2) cyc;
        #1 check("full_count", count, 66);
        check("full_s_ready", s_ready, 0);
        check("full_m_valid", m_valid, 1);
        check("full_head", m_data, 0);

        // Write refused while full, pop proceeds in the same cycle
        cyc; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
        #1 check("full_wr_ready", s_ready, 0);
        check("full_wr_we", ram_we, 0);
        check("full_pop_data", m_data, 0);
        e = 1;
        for (int c = 0; c < 200 && e < 66; c++) begin
            cyc; s_valid = 1'b0;
            #1;
            if (c == 0) check("full_ready_rise", s_ready, 1);
            if (m_valid) begin
                check("drain_data", m_data, e);
                e++;
            end
        end
        check("drain_all", e, 66);
        cyc; #1 check("drain_count", count, 0);
        check("drain_m_valid", m_valid, 0);

        // Streaming 200 words, full throughput, pointer wrap
        wi = 0; ri = 0; seen = 1'b0;
        for (int c = 0; c < 260 && ri < 200; c++) begin
            cyc; s_valid = (wi < 200); s_data = DW'(wi); m_ready = 1'b1;
            #1;
            if (s_valid) check("stream_ready", s_ready, 1);
            check("stream_cnt_le3", (count <= 3), 1);
            if (s_valid && s_ready) wi++;
            if (seen || m_valid) begin
                check("stream_no_bubble", m_valid, 1);
                if (m_valid) begin
                    check("stream_data", m_data, ri[DW-1:0]);
                    ri++;
                end
                seen = 1'b1;
            end
        end
        check("stream_all", ri, 200);
        s_valid = 1'b0;
        cyc; #1 check("stream_count", count, 0);

        // Random backpressure against a scoreboard
        nacc = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 6000 && (nacc < 1000 || sb.size() > 0); c++) begin
            cyc;
            s_valid = (nacc < 1000) && ($urandom_range(0, 1) == 1);
            s_data  = DW'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            #1;
            check("bp_count", count, sb.size());
            if (prev_stall) begin
                check("bp_hold_valid", m_valid, 1);
                check("bp_hold_data", m_data, prev_data);
            end
            if (m_valid && sb.size() == 0)
                check("bp_spurious", m_valid, 0);
            if (m_valid && m_ready && sb.size() > 0)
                check("bp_data", m_data, sb.pop_front());
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                nacc++;
            end
        end
        check("bp_accepted", nacc, 1000);
        check("bp_drained", sb.size(), 0);

        // Mid-operation reset discards everything
        cyc; s_valid = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc; s_valid = 1'b1; s_data = DW'(8'h40 + i);
        end
        cyc; s_valid = 1'b0; rst_n = 1'b0;
        cyc; rst_n = 1'b1;
        #1 check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_s_ready", s_ready, 0);
        cyc; #1 check("mid_rel_s_ready", s_ready, 1);
        s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
        cyc; s_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (m_valid) begin
                check("mid_first_out", m_data, 8'h3C);
                got = 1'b1;
            end else begin
                cyc;
            end
        end
        check("mid_out_seen", got, 1);
        cyc; #1 check("mid_end_count", count, 0);
        check("mid_end_valid", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the team's simple dual-port RAM (registered read, 1-cycle latency, no reset).
- Converts a valid/ready write stream and a valid/ready read stream into the RAM's we/data/write_addr/read_addr controls, and consumes the RAM's q output.
- Hides the RAM read latency with a 2-entry output buffer, so the read side sustains full throughput.
- Total capacity is 2**ADDR_WIDTH + 2 words.

Parameters:
- ADDR_WIDTH, 6, RAM address width; RAM depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data word width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  write-side data valid.
- s_ready  out  1  write-side ready; a word is accepted on s_valid & s_ready.
- s_data  in  DATA_WIDTH  write-side data.
- m_valid  out  1  read-side data valid.
- m_ready  in  1  read-side ready; a word is consumed on m_valid & m_ready.
- m_data  out  DATA_WIDTH  read-side data (head of output buffer).
- count  out  ADDR_WIDTH+2  total words held: RAM + in-flight read + output buffer.
- ram_we  out  1  to RAM we.
- ram_wdata  out  DATA_WIDTH  to RAM data.
- ram_waddr  out  ADDR_WIDTH  to RAM write_addr.
- ram_raddr  out  ADDR_WIDTH  to RAM read_addr.
- ram_q  in  DATA_WIDTH  from RAM q; valid the cycle after a read is issued.

Behaviour:
- Reset: sampled on posedge clk while rst_n=0.
  - Clears wptr, rptr, the pending flag, output buffer occupancy and count.
  - Outputs during and after reset: s_ready=0 while rst_n=0, then 1 from the first cycle after rst_n rises; m_valid=0; count=0; ram_we=0.
  - RAM contents are not cleared.
  - A reset mid-operation discards all words, including any in-flight read.
- Pointers: wptr and rptr are ADDR_WIDTH+1 bits. The RAM address is the low ADDR_WIDTH bits; the MSB is a wrap flag.
  - ram_cnt = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - RAM full when ram_cnt == 2**ADDR_WIDTH; RAM empty when ram_cnt == 0.
- Write path:
  - s_ready = rst_n_q & ~ram_full, where rst_n_q is rst_n registered so that s_ready=0 during reset as specified above.
  - s_ready is a registered-state function only: no combinational path from m_ready.
  - ram_we = s_valid & s_ready (combinational); ram_waddr = wptr[ADDR_WIDTH-1:0]; ram_wdata = s_data.
  - wptr increments on accept.
- Read issue: rd_issue = ~ram_empty & (buf_occ + pending - pop) < 2, where pop = m_valid & m_ready.
  - On rd_issue: ram_raddr = rptr[ADDR_WIDTH-1:0], rptr increments, pending <= 1; otherwise pending <= 0.
  - ram_raddr holds rptr when idle.
  - A word written in cycle t is not visible in ram_cnt until cycle t+1, so a read never targets an address written in the same cycle.
- Capture: when pending=1, ram_q is pushed into the output buffer that cycle, behind any held entry.
- Output buffer:
  - 2-entry FIFO; m_valid = buf_occ != 0; m_data = head entry.
  - m_data is stable while m_valid & ~m_ready.
  - Push and pop in the same cycle are allowed; occupancy is unchanged and the entries shift.
  - Overflow is impossible by the issue rule.
- Latency: word accepted at cycle 0 into an empty FIFO -> read issued at cycle 1 -> ram_q valid and captured at cycle 2 -> m_valid=1 with that word at cycle 3.
- Throughput: with s_valid=1 and m_ready=1 continuously, one word per cycle on both sides after the initial 3-cycle latency; no bubbles.
- Count: count = ram_cnt + pending + buf_occ, registered.
  - Updates +1 on write-only, -1 on pop-only, unchanged when both occur.
  - Maximum value 2**ADDR_WIDTH + 2.
- Simultaneous write and pop when the RAM is full: the write is refused (s_ready=0 that cycle); the pop proceeds; s_ready rises the cycle after a read issue frees a RAM slot.
- Wrap-around: pointers wrap naturally; ordering is preserved across the address wrap from 63 to 0.
- No error or overflow outputs: writes when s_ready=0 and m_ready when m_valid=0 are ignored.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with s_valid=1 -> s_ready=0, m_valid=0, count=0, ram_we=0; s_ready=1 the cycle after release.
- Single word: write 0xA5 at cycle 0 with m_ready=1 -> ram_raddr=0 issued at cycle 1, m_valid=1 and m_data=0xA5 at cycle 3, count returns to 0 at cycle 4.
- Fill: write 0..65 with m_ready=0 -> all 66 accepted (64 in RAM + 2 in buffer), count=66, s_ready=0; drain -> m_data reads 0..65 in order.
- Streaming: 200 consecutive words with s_valid=m_ready=1 -> 200 outputs on consecutive cycles in order, pointer wrap at 64 and 128 transparent, count never exceeds 3.
- Backpressure: random m_ready (about 50%) and random s_valid over 1000 words -> scoreboard order and data match, m_data stable while stalled, count equals scoreboard depth every cycle.
- Mid-operation reset: 10 words in flight, pulse rst_n=0 for 1 cycle -> m_valid=0 and count=0 next cycle; a subsequent write of 0x3C emerges as the first output.
